// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace path: the record that
// travels through the trace FIFO and the widths of the bookkeeping counters.
package trace_pkg;

  // Record payload width; the top-level XLEN parameter is expected to match.
  localparam int TRACE_XLEN = 32;
  localparam int SEQ_W      = 32;
  localparam int DROP_W     = 16;
  localparam int RD_W       = 6;
  localparam int INSTRET_W  = 64;

  typedef struct packed {
    logic [SEQ_W-1:0]      seq;
    logic                  has_reg;
    logic                  has_st;
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] inst;
    logic [RD_W-1:0]       rd;
    logic [TRACE_XLEN-1:0] data;
    logic [TRACE_XLEN-1:0] st_addr;
    logic [TRACE_XLEN-1:0] st_data;
  } commit_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic show-ahead FIFO. The head entry is read combinationally from the
// storage array so a consumer sees it the cycle after it was written. A push
// into a full FIFO is still accepted when a pop happens in the same cycle.
module trace_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  output T              o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures the retirement stream (register and store commits) into timestamped
// records and streams them out over valid/ready. The core side never stalls:
// when the FIFO cannot take a record it is dropped and the loss is counted.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = TRACE_XLEN  // must equal TRACE_XLEN (record layout)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [XLEN-1:0]          commit_inst,
  input  logic [5:0]               commit_Ard,
  input  logic [XLEN-1:0]          commit_data,
  input  logic                     st_commit,
  input  logic [XLEN-1:0]          st_addr,
  input  logic [XLEN-1:0]          st_data,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [31:0]              rec_seq,
  output logic                     rec_has_reg,
  output logic                     rec_has_st,
  output logic [XLEN-1:0]          rec_pc,
  output logic [XLEN-1:0]          rec_inst,
  output logic [XLEN-1:0]          rec_data,
  output logic [XLEN-1:0]          rec_st_addr,
  output logic [XLEN-1:0]          rec_st_data,
  output logic [5:0]               rec_rd,
  output logic [63:0]              instret,
  output logic [15:0]              drop_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  logic [SEQ_W-1:0]     r_seq;
  logic [INSTRET_W-1:0] r_instret;
  logic [DROP_W-1:0]    r_drop_cnt;
  logic                 r_overflow;

  commit_rec_t          w_rec;
  commit_rec_t          w_head;
  logic                 w_event;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;

  assign w_event = commit_valid | st_commit;
  assign w_pop   = ~w_empty & rec_ready;
  // Only a full FIFO without a simultaneous pop loses the record.
  assign w_drop  = w_event & w_full & ~w_pop;

  // Record build: each half is zeroed when its source is idle this cycle.
  always_comb begin
    w_rec         = '0;
    w_rec.seq     = r_seq;
    w_rec.has_reg = commit_valid;
    w_rec.has_st  = st_commit;
    if (commit_valid) begin
      w_rec.pc   = commit_pc;
      w_rec.inst = commit_inst;
      w_rec.rd   = commit_Ard;
      w_rec.data = commit_data;
    end
    if (st_commit) begin
      w_rec.st_addr = st_addr;
      w_rec.st_data = st_data;
    end
  end

  trace_fifo #(
    .T     (commit_rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_event),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  // Sequence, retire and loss bookkeeping; seq advances even for drops so a
  // gap in the delivered sequence numbers exposes the loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seq      <= '0;
      r_instret  <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_event)      r_seq     <= r_seq + 1'b1;
      if (commit_valid) r_instret <= r_instret + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != {DROP_W{1'b1}}) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign rec_valid   = ~w_empty;
  assign rec_seq     = w_head.seq;
  assign rec_has_reg = w_head.has_reg;
  assign rec_has_st  = w_head.has_st;
  assign rec_pc      = w_head.pc;
  assign rec_inst    = w_head.inst;
  assign rec_rd      = w_head.rd;
  assign rec_data    = w_head.data;
  assign rec_st_addr = w_head.st_addr;
  assign rec_st_data = w_head.st_data;
  assign instret     = r_instret;
  assign drop_cnt    = r_drop_cnt;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: two instances (DEPTH 4 and 16) share the
// commit stream but have independent consumers. A queue-based model of the
// record stream predicts every head record and counter after each edge.
module tb_commit_trace_buffer;

  typedef struct {
    logic [31:0] seq;
    logic        has_reg;
    logic        has_st;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  rd;
    logic [31:0] data;
    logic [31:0] st_addr;
    logic [31:0] st_data;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0, commit_inst = '0, commit_data = '0;
  logic [5:0]  commit_Ard = '0;
  logic        st_commit = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0;
  logic        rdy4 = 1'b0, rdy16 = 1'b0;

  logic        v4, hr4, hs4, ovf4;
  logic [31:0] seq4, pc4, inst4, data4, sa4, sd4;
  logic [5:0]  rd4;
  logic [63:0] ir4;
  logic [15:0] drop4;
  logic [2:0]  cnt4;

  logic        v16, hr16, hs16, ovf16;
  logic [31:0] seq16, pc16, inst16, data16, sa16, sd16;
  logic [5:0]  rd16;
  logic [63:0] ir16;
  logic [15:0] drop16;
  logic [4:0]  cnt16;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  rec_t        q4[$];
  rec_t        q16[$];
  logic [31:0] seq_m = '0;
  logic [63:0] instret_m = '0;
  logic [15:0] drop4_m = '0, drop16_m = '0;
  logic        ovf4_m = 1'b0, ovf16_m = 1'b0;
  int          delivered16 = 0;
  logic [31:0] last_seq16 = '0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(4), .XLEN(32)) u4 (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .commit_Ard(commit_Ard), .commit_data(commit_data),
    .st_commit(st_commit), .st_addr(st_addr), .st_data(st_data),
    .rec_valid(v4), .rec_ready(rdy4), .rec_seq(seq4), .rec_has_reg(hr4),
    .rec_has_st(hs4), .rec_pc(pc4), .rec_inst(inst4), .rec_data(data4),
    .rec_st_addr(sa4), .rec_st_data(sd4), .rec_rd(rd4), .instret(ir4),
    .drop_cnt(drop4), .overflow(ovf4), .count(cnt4)
  );

  commit_trace_buffer #(.DEPTH(16), .XLEN(32)) u16 (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .commit_Ard(commit_Ard), .commit_data(commit_data),
    .st_commit(st_commit), .st_addr(st_addr), .st_data(st_data),
    .rec_valid(v16), .rec_ready(rdy16), .rec_seq(seq16), .rec_has_reg(hr16),
    .rec_has_st(hs16), .rec_pc(pc16), .rec_inst(inst16), .rec_data(data16),
    .rec_st_addr(sa16), .rec_st_data(sd16), .rec_rd(rd16), .instret(ir16),
    .drop_cnt(drop16), .overflow(ovf16), .count(cnt16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input rec_t obs, input rec_t exp);
    chk({tag, ".seq"},     obs.seq,     exp.seq);
    chk({tag, ".has_reg"}, obs.has_reg, exp.has_reg);
    chk({tag, ".has_st"},  obs.has_st,  exp.has_st);
    chk({tag, ".pc"},      obs.pc,      exp.pc);
    chk({tag, ".inst"},    obs.inst,    exp.inst);
    chk({tag, ".rd"},      obs.rd,      exp.rd);
    chk({tag, ".data"},    obs.data,    exp.data);
    chk({tag, ".st_addr"}, obs.st_addr, exp.st_addr);
    chk({tag, ".st_data"}, obs.st_data, exp.st_data);
  endtask

  task automatic check_all();
    rec_t h4, h16;
    h4  = '{seq4, hr4, hs4, pc4, inst4, rd4, data4, sa4, sd4};
    h16 = '{seq16, hr16, hs16, pc16, inst16, rd16, data16, sa16, sd16};
    chk("u4.valid",    v4,    q4.size() != 0);
    chk("u4.count",    cnt4,  q4.size());
    chk("u4.instret",  ir4,   instret_m);
    chk("u4.drop",     drop4, drop4_m);
    chk("u4.ovf",      ovf4,  ovf4_m);
    if (q4.size() != 0) chk_rec("u4.head", h4, q4[0]);
    chk("u16.valid",   v16,    q16.size() != 0);
    chk("u16.count",   cnt16,  q16.size());
    chk("u16.instret", ir16,   instret_m);
    chk("u16.drop",    drop16, drop16_m);
    chk("u16.ovf",     ovf16,  ovf16_m);
    if (q16.size() != 0) chk_rec("u16.head", h16, q16[0]);
  endtask

  // Model of one clock edge from the currently driven inputs.
  task automatic model_step();
    rec_t r;
    bit   ev;
    ev = commit_valid | st_commit;
    r.seq     = seq_m;
    r.has_reg = commit_valid;
    r.has_st  = st_commit;
    r.pc      = commit_valid ? commit_pc   : 32'h0;
    r.inst    = commit_valid ? commit_inst : 32'h0;
    r.rd      = commit_valid ? commit_Ard  : 6'h0;
    r.data    = commit_valid ? commit_data : 32'h0;
    r.st_addr = st_commit ? st_addr : 32'h0;
    r.st_data = st_commit ? st_data : 32'h0;
    if (q4.size() != 0 && rdy4) void'(q4.pop_front());
    if (q16.size() != 0 && rdy16) begin
      delivered16++;
      last_seq16 = q16[0].seq;
      void'(q16.pop_front());
    end
    if (ev) begin
      if (q4.size() < 4) q4.push_back(r);
      else begin
        ovf4_m = 1'b1;
        if (drop4_m != 16'hFFFF) drop4_m++;
      end
      if (q16.size() < 16) q16.push_back(r);
      else begin
        ovf16_m = 1'b1;
        if (drop16_m != 16'hFFFF) drop16_m++;
      end
      seq_m++;
    end
    if (commit_valid) instret_m++;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    commit_valid = 1'b0; st_commit = 1'b0;
    commit_pc = '0; commit_inst = '0; commit_Ard = '0; commit_data = '0;
    st_addr = '0; st_data = '0;
  endtask

  task automatic rand_commit();
    commit_valid = 1'b1; st_commit = 1'b0;
    commit_pc = $urandom; commit_inst = $urandom;
    commit_Ard = 6'($urandom_range(0, 63)); commit_data = $urandom;
  endtask

  task automatic model_reset();
    q4.delete(); q16.delete();
    seq_m = '0; instret_m = '0;
    drop4_m = '0; drop16_m = '0; ovf4_m = 1'b0; ovf16_m = 1'b0;
    delivered16 = 0; last_seq16 = '0;
  endtask

  // Asynchronous reset applied mid-cycle; outputs checked before the next edge.
  task automatic do_reset(input string tag);
    idle();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, ".valid4"},  v4, 1'b0);
    chk({tag, ".count4"},  cnt4, 0);
    chk({tag, ".valid16"}, v16, 1'b0);
    chk({tag, ".count16"}, cnt16, 0);
    chk({tag, ".instret"}, ir16, 0);
    chk({tag, ".drop"},    drop16, 0);
    chk({tag, ".ovf"},     ovf16, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // Power-on reset
    do_reset("por");

    // Single commit, consumer ready
    rdy4 = 1'b1; rdy16 = 1'b1;
    commit_valid = 1'b1; commit_pc = 32'h1000; commit_inst = 32'h00A00093;
    commit_Ard = 6'd1; commit_data = 32'hA;
    step();
    chk("single.valid", v16, 1'b1);
    chk("single.seq", seq16, 0);
    chk("single.has_reg", hr16, 1'b1);
    chk("single.has_st", hs16, 1'b0);
    chk("single.rd", rd16, 1);
    chk("single.data", data16, 32'hA);
    idle();
    step();
    chk("single.popped", v16, 1'b0);
    chk("single.instret", ir16, 1);

    // Commit plus store in the same cycle
    rdy4 = 1'b0; rdy16 = 1'b0;
    rand_commit();
    st_commit = 1'b1; st_addr = 32'h3FFF; st_data = 32'hFFFFFFFF;
    step();
    chk("both.has_reg", hr16, 1'b1);
    chk("both.has_st", hs16, 1'b1);
    chk("both.st_addr", sa16, 32'h3FFF);
    chk("both.st_data", sd16, 32'hFFFFFFFF);
    chk("both.count", cnt16, 1);

    // Queue up to five records, then reset mid-stream
    for (int i = 0; i < 4; i++) begin rand_commit(); step(); end
    chk("pre_rst.count", cnt16, 5);
    do_reset("midrst");

    // Overflow on DEPTH=4 with no consumer
    rdy4 = 1'b0; rdy16 = 1'b0;
    for (int i = 0; i < 6; i++) begin rand_commit(); step(); end
    chk("ovf.count", cnt4, 4);
    chk("ovf.drop", drop4, 2);
    chk("ovf.flag", ovf4, 1'b1);
    chk("ovf.instret", ir4, 6);
    idle();
    rdy4 = 1'b1; rdy16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain.seq", seq4, 32'(i));
      step();
    end
    chk("drain.empty", v4, 1'b0);
    for (int i = 0; i < 4; i++) step();

    // Full FIFO with simultaneous push and pop
    do_reset("rst2");
    rdy4 = 1'b0; rdy16 = 1'b0;
    for (int i = 0; i < 4; i++) begin rand_commit(); step(); end
    rdy4 = 1'b1;
    rand_commit();
    step();
    chk("pp.count", cnt4, 4);
    chk("pp.drop", drop4, 0);
    chk("pp.head", seq4, 1);
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("pp.order", seq4, 32'(i + 1));
      step();
    end

    // 20 back-to-back random events with a stalling consumer on DEPTH=16
    do_reset("rst3");
    for (int i = 0; i < 20; i++) begin
      rand_commit();
      commit_valid = 1'($urandom);
      st_commit = commit_valid ? 1'($urandom) : 1'b1;
      st_addr = $urandom; st_data = $urandom;
      rdy16 = (i % 2 == 0) ? 1'b1 : 1'($urandom);
      rdy4 = 1'($urandom);
      step();
    end
    idle();
    rdy4 = 1'b1; rdy16 = 1'b1;
    for (int i = 0; i < 40 && (q16.size() != 0 || v16); i++) step();
    chk("burst.empty", v16, 1'b0);
    chk("burst.delivered", delivered16, 20);
    chk("burst.last_seq", last_seq16, 19);
    chk("burst.drop", drop16, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Captures the core's retirement stream (register commits and store commits) into a small FIFO of timestamped records. It then presents those records over a valid/ready stream to a trace consumer, such as the commit tracker or an off-core trace port. It sits directly downstream of the core's debug commit ports. It decouples the un-stallable commit stream from a consumer that may stall. Losses are counted, never hidden.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- XLEN, 32: width of pc/inst/data/address fields.
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- commit_valid  in  1  an instruction retires this cycle.
- commit_pc  in  XLEN  PC of the retiring instruction.
- commit_inst  in  XLEN  instruction word.
- commit_Ard  in  6  architectural rd; 0 = no register write.
- commit_data  in  XLEN  rd write data.
- st_commit  in  1  a store retires to memory this cycle.
- st_addr  in  XLEN  store byte address.
- st_data  in  XLEN  store data.
- rec_valid  out  1  a record is available at the head.
- rec_ready  in  1  consumer accepts the head record.
- rec_seq  out  32  record sequence number.
- rec_has_reg / rec_has_st  out  1 each  record carries a commit part / a store part.
- rec_pc, rec_inst, rec_data, rec_st_addr, rec_st_data  out  XLEN each  captured fields.
- rec_rd  out  6  captured commit_Ard.
- instret  out  64  retired-instruction count.
- drop_cnt  out  16  records lost to overflow.
- overflow  out  1  sticky drop flag.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Event cycle: commit_valid | st_commit. Each event cycle produces exactly one record, so only one push per cycle is possible.
- Record fields:
  - has_reg = commit_valid; has_st = st_commit.
  - Commit fields are captured only if has_reg, otherwise zero. Store fields are captured only if has_st, otherwise zero.
  - seq = value of the seq counter at capture.
- seq counter, 32 bit, wraps: increments on every event cycle, including dropped ones. A gap in rec_seq therefore marks a loss.
- instret, 64 bit, wraps: increments on every commit_valid cycle, independent of FIFO state.
- Push is accepted iff count<DEPTH, or a pop happens in the same cycle.
- Dropped push:
  - The FIFO is unchanged.
  - drop_cnt increments, saturating at 16'hFFFF.
  - overflow is set and held until reset.
- Pop happens when rec_valid & rec_ready.
- rec_valid = (count≠0). Head fields come combinationally from the entry array at rd_ptr (show-ahead).
- Head fields are undefined when rec_valid=0; the consumer must ignore them.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count tracks occupancy: push only +1, pop only −1, both 0.
- Reset (asynchronous, any time, including mid-stream):
  - The FIFO is emptied.
  - count, seq, instret, drop_cnt and overflow go to 0; rec_valid=0.
  - Entry contents need not be reset.

## Timing
- Capture latency: an event sampled at rising edge N is visible as the head (rec_valid=1) in cycle N+1, when the FIFO was empty.
- Pop: the head advances at the edge where rec_valid&rec_ready is sampled. The next record is visible the following cycle, giving throughput of 1 record/cycle.
- Same-cycle push+pop while full: both take effect, no drop, count stays DEPTH.
- Same-cycle push+pop while count=1: the new record becomes head next cycle and rec_valid stays 1.
- rec_ready may toggle freely; record fields stay stable while rec_valid=1 and no pop occurs.
- The core is never backpressured: there is no ready output toward it.

## Structure
- trace_pkg holds:
  - commit_rec_t: packed struct {seq, has_reg, has_st, pc, inst, rd, data, st_addr, st_data}.
  - The SEQ_W=32 and DROP_W=16 constants.
- Sub-module trace_fifo: a generic synchronous show-ahead FIFO parameterised on type and DEPTH, with push/pop/full/empty/count.
- commit_trace_buffer adds the record build, the counters and the drop logic around trace_fifo.

## Test plan
- Reset: assert rst mid-stream with 5 records queued → rec_valid=0, count=0, instret=0, drop_cnt=0, overflow=0, asynchronously and before the next edge.
- Single commit of pc=0x1000, inst=0x00A00093, Ard=1, data=0xA, with rec_ready=1 → exactly one cycle later:
  - rec_valid=1, seq=0, has_reg=1, has_st=0, rd=1, data=0xA.
  - Popped next edge; instret=1.
- Commit plus store in the same cycle (st_addr=0x3FFF, st_data=0xFFFFFFFF) → one record with has_reg=1, has_st=1 and both field sets correct; count=1.
- DEPTH=4, rec_ready=0, 6 consecutive commits → count=4, drop_cnt=2, overflow=1, instret=6. Draining yields seq 0,1,2,3 in order.
- Full FIFO with push and pop in the same cycle → no drop, count stays 4, new record lands at the tail with the next seq.
- 20 back-to-back events with random rec_ready (≥1 ready in 2) and DEPTH=16 → all records delivered in order with seq 0..19 and no drops, including pointer wrap-around.
